// File: rtl/adc_pkg.sv
// Shared widths and FSM encoding for the ADC averaging path.
package adc_pkg;

  localparam int SAMPLE_WIDTH = 10;
  localparam int ACC_WIDTH    = 14;
  localparam int CNT_WIDTH    = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } avg_state_t;

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through queue for averaged samples; head is visible while not empty.
module sample_fifo
  import adc_pkg::*;
#(
  parameter int  DATA_W = SAMPLE_WIDTH,
  parameter int  DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int LVL_W  = PTR_W + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop_req,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full,
  output logic [LVL_W-1:0]  level
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  count;
  logic [DATA_W-1:0] hold;
  logic              pop;
  logic              wr;

  assign empty = (count == '0);
  assign full  = (count == LVL_W'(DEPTH));
  assign level = count;

  // A pop frees a slot in the same clock, so a push into a full queue still lands.
  assign pop = pop_req & ~empty;
  assign wr  = push & (~full | pop);

  assign head = empty ? hold : mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hold   <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        hold   <= mem[rd_ptr];
      end
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (wr) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/adc_averager.sv
// Brings ADC samples into the system clock via a toggle handshake, boxcar-averages
// 2^AVG_LOG2 of them and queues the results for a valid/ready consumer.
module adc_averager
  import adc_pkg::*;
#(
  parameter int  AVG_LOG2   = 2,
  parameter int  FIFO_DEPTH = 4,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_toggle,
  input  logic                    enable,
  output logic [SAMPLE_WIDTH-1:0] avg_out,
  output logic                    avg_valid,
  input  logic                    avg_ready,
  output logic [LVL_W-1:0]        level,
  output logic                    overflow
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(1 << AVG_LOG2);

  // Truncating divide by the group size; the sum never exceeds ACC_WIDTH bits.
  function automatic logic [SAMPLE_WIDTH-1:0] avg_trunc(input logic [ACC_WIDTH-1:0] a);
    logic [ACC_WIDTH-1:0] s;
    s = a >> AVG_LOG2;
    return s[SAMPLE_WIDTH-1:0];
  endfunction

  logic                    tog_p0;
  logic                    tog_p1;
  logic                    tog_p2;
  logic                    new_sample;
  avg_state_t              state;
  logic [ACC_WIDTH-1:0]    acc;
  logic [CNT_WIDTH-1:0]    cnt;
  logic                    push;
  logic [SAMPLE_WIDTH-1:0] push_data;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    fifo_drop;

  // Stage p0..p2: two-flop synchroniser plus an edge-detect flop on the toggle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tog_p0 <= 1'b0;
      tog_p1 <= 1'b0;
      tog_p2 <= 1'b0;
    end else begin
      tog_p0 <= sample_toggle;
      tog_p1 <= tog_p0;
      tog_p2 <= tog_p1;
    end
  end

  // sample_in is held for thousands of clocks after a toggle, so it is sampled directly.
  assign new_sample = tog_p1 ^ tog_p2;

  // Accumulate / emit stage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else if (!enable) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (fifo_drop) overflow <= 1'b1;
      case (state)
        IDLE: begin
          acc   <= '0;
          cnt   <= '0;
          state <= ACCUM;
        end
        ACCUM: begin
          if (new_sample) begin
            acc <= acc + ACC_WIDTH'(sample_in);
            cnt <= cnt + CNT_WIDTH'(1);
            if (cnt + CNT_WIDTH'(1) == CNT_LAST) state <= EMIT;
          end
        end
        EMIT: begin
          acc   <= '0;
          cnt   <= '0;
          state <= ACCUM;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign push      = (state == EMIT);
  assign push_data = avg_trunc(acc);
  assign fifo_drop = push & fifo_full & ~(avg_ready & ~fifo_empty);
  assign avg_valid = ~fifo_empty;

  // Output queue stage.
  sample_fifo #(
    .DATA_W (SAMPLE_WIDTH),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop_req   (avg_ready),
    .head      (avg_out),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (level)
  );

endmodule

// File: tb/tb_adc_averager.sv
// Self-checking bench for adc_averager: table vectors, timed corner sequences and
// randomized groups checked against a queue-based reference model.
module tb_adc_averager;

  localparam int L2    = 2;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic [9:0] sample_in;
  logic       sample_toggle;
  logic       enable;
  logic       avg_ready;
  logic [9:0] avg_out;
  logic       avg_valid;
  logic [2:0] level;
  logic       overflow;

  logic [9:0] s0_in;
  logic       t0, en0, r0;
  logic [9:0] a0_out;
  logic       a0_valid, ov0;
  logic [2:0] lvl0;

  adc_averager #(.AVG_LOG2(L2), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .sample_in(sample_in), .sample_toggle(sample_toggle),
    .enable(enable), .avg_out(avg_out), .avg_valid(avg_valid), .avg_ready(avg_ready),
    .level(level), .overflow(overflow));

  adc_averager #(.AVG_LOG2(0), .FIFO_DEPTH(DEPTH)) dut0 (
    .clock(clock), .reset(reset), .sample_in(s0_in), .sample_toggle(t0),
    .enable(en0), .avg_out(a0_out), .avg_valid(a0_valid), .avg_ready(r0),
    .level(lvl0), .overflow(ov0));

  typedef struct {
    int s[4];
    int exp;
  } vec_t;

  vec_t tbl[5];
  int   model_q[$];
  int   grp[4];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic feed(input int v);
    sample_in     = 10'(v);
    sample_toggle = ~sample_toggle;
    tick(6);
  endtask

  function automatic int avg_of(input int v[4]);
    return (v[0] + v[1] + v[2] + v[3]) >> L2;
  endfunction

  // Feeds one full group and records its expected average (dropped if the queue is full).
  task automatic feed_group(input int v[4]);
    for (int i = 0; i < 4; i++) feed(v[i]);
    if (model_q.size() < DEPTH) model_q.push_back(avg_of(v));
  endtask

  task automatic rand_group();
    for (int i = 0; i < 4; i++) grp[i] = int'($urandom_range(0, 1023));
  endtask

  task automatic pop_check(input string name);
    int exp;
    exp = model_q.pop_front();
    check({name, "_valid"}, avg_valid, 1);
    check({name, "_data"}, avg_out, exp);
    avg_ready = 1'b1;
    tick(1);
    avg_ready = 1'b0;
  endtask

  task automatic drain(input string name);
    while (model_q.size() > 0) begin
      check({name, "_level"}, level, model_q.size());
      pop_check(name);
    end
    check({name, "_empty"}, avg_valid, 0);
  endtask

  initial begin
    tbl[0] = '{s: '{0, 0, 0, 0},             exp: 0};
    tbl[1] = '{s: '{1023, 1023, 1023, 1023}, exp: 1023};
    tbl[2] = '{s: '{1, 1, 1, 0},             exp: 0};
    tbl[3] = '{s: '{1023, 1023, 1023, 1022}, exp: 1022};
    tbl[4] = '{s: '{10, 20, 30, 43},         exp: 25};

    reset = 1'b0; enable = 1'b0; avg_ready = 1'b0; sample_in = '0; sample_toggle = 1'b0;
    s0_in = '0; t0 = 1'b0; en0 = 1'b0; r0 = 1'b0;
    #1;
    check("rst_valid", avg_valid, 0);
    check("rst_level", level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_avg_out", avg_out, 0);
    tick(2);
    reset = 1'b1;
    tick(2);

    // First group with exact latency: valid rises on the 4th edge after the last toggle.
    enable = 1'b1;
    tick(2);
    feed(100); feed(200); feed(300);
    sample_in = 10'd401;
    sample_toggle = ~sample_toggle;
    repeat (3) @(posedge clock);
    #1 check("t1_valid_early", avg_valid, 0);
    @(posedge clock);
    #1 check("t1_valid", avg_valid, 1);
    check("t1_avg", avg_out, 250);
    check("t1_level", level, 1);
    @(negedge clock);
    avg_ready = 1'b1;
    tick(1);
    avg_ready = 1'b0;
    check("t1_level_after_pop", level, 0);
    tick(4);

    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 4; i++) feed(tbl[k].s[i]);
      check($sformatf("tbl%0d_valid", k), avg_valid, 1);
      check($sformatf("tbl%0d_level", k), level, 1);
      check($sformatf("tbl%0d_avg", k), avg_out, tbl[k].exp);
      avg_ready = 1'b1;
      tick(1);
      avg_ready = 1'b0;
    end

    // Passthrough instance: each word visible for exactly one clock with ready held high.
    en0 = 1'b1; r0 = 1'b1;
    tick(2);
    s0_in = 10'h3FF; t0 = ~t0;
    repeat (3) @(posedge clock);
    #1 check("p0_a_early", a0_valid, 0);
    @(posedge clock);
    #1 check("p0_a_valid", a0_valid, 1);
    check("p0_a_data", a0_out, 10'h3FF);
    @(posedge clock);
    #1 check("p0_a_gone", a0_valid, 0);
    @(negedge clock);
    tick(3);
    s0_in = 10'h000; t0 = ~t0;
    repeat (4) @(posedge clock);
    #1 check("p0_b_valid", a0_valid, 1);
    check("p0_b_data", a0_out, 0);
    @(posedge clock);
    #1 check("p0_b_gone", a0_valid, 0);
    check("p0_overflow", ov0, 0);
    @(negedge clock);

    for (int r = 0; r < 3; r++) begin
      int ng;
      ng = int'($urandom_range(1, 4));
      for (int g = 0; g < ng; g++) begin
        rand_group();
        feed_group(grp);
      end
      check($sformatf("rnd%0d_overflow", r), overflow, 0);
      drain($sformatf("rnd%0d", r));
    end

    // Five groups into a four-deep queue: the fifth is dropped and overflow sticks.
    for (int g = 0; g < 5; g++) begin
      rand_group();
      feed_group(grp);
    end
    check("ovf_level", level, 4);
    check("ovf_flag", overflow, 1);
    drain("ovf");
    check("ovf_sticky", overflow, 1);

    // Partial group discarded by enable low; overflow cleared.
    feed(500); feed(600);
    enable = 1'b0;
    tick(2);
    check("en_overflow_cleared", overflow, 0);
    enable = 1'b1;
    tick(2);
    grp = '{8, 8, 8, 8};
    feed_group(grp);
    check("en_level", level, 1);
    drain("en");

    // Full queue, push and pop in the same clock.
    for (int g = 0; g < 4; g++) begin
      rand_group();
      feed_group(grp);
    end
    rand_group();
    for (int i = 0; i < 3; i++) feed(grp[i]);
    sample_in = 10'(grp[3]);
    sample_toggle = ~sample_toggle;
    tick(3);
    check("fp_head", avg_out, model_q[0]);
    avg_ready = 1'b1;
    tick(1);
    avg_ready = 1'b0;
    void'(model_q.pop_front());
    model_q.push_back(avg_of(grp));
    check("fp_level", level, 4);
    check("fp_overflow", overflow, 0);
    tick(2);
    drain("fp");

    // Asynchronous reset with two queued results and a partial group in flight.
    for (int g = 0; g < 2; g++) begin
      rand_group();
      feed_group(grp);
    end
    feed(700); feed(900);
    #2 reset = 1'b0;
    sample_toggle = 1'b0;
    #1;
    check("ar_valid", avg_valid, 0);
    check("ar_level", level, 0);
    model_q.delete();
    tick(2);
    reset = 1'b1;
    tick(2);
    rand_group();
    feed_group(grp);
    check("ar_overflow", overflow, 0);
    drain("ar");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
